// File: rtl/frame_serializer.sv
// Captures a 10x20 game frame and shifts it row-major into a daisy-chained
// LED driver, double-buffering frames that arrive mid-transfer.
package game_state_pkg;
    localparam int GAME_COLS = 10;
    localparam int GAME_ROWS = 20;

    typedef struct packed {
        logic [GAME_COLS-1:0][GAME_ROWS-1:0] screen;
        logic [15:0]                         score;
        logic [3:0]                          level;
        logic                                game_over;
    } game_state_t;
endpackage

module frame_serializer
    import game_state_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int N_COLS  = 10,
    parameter int N_ROWS  = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        GAME_new_frame_ready,
    input  game_state_t GAME_next_frame,
    output logic        DISP_sdata,
    output logic        DISP_sclk,
    output logic        DISP_latch,
    output logic        DISP_busy,
    output logic        DISP_frame_done
);

    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);

    typedef logic [N_COLS-1:0][N_ROWS-1:0] screen_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    div_q, div_d;
    logic          pend_q, pend_d;
    screen_t       act_q, act_d;
    screen_t       pbuf_q, pbuf_d;
    logic          sdata_q, sdata_d;
    logic          sclk_q, sclk_d;
    logic          latch_q, latch_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div_last;

    // Only the screen is displayed; the remaining fields are ignored.
    logic unused_fields;
    assign unused_fields = ^{GAME_next_frame.score,
                             GAME_next_frame.level,
                             GAME_next_frame.game_over};

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        pend_d   = pend_q;
        act_d    = act_q;
        pbuf_d   = pbuf_q;
        div_last = (div_q == DIV_LAST);

        unique case (state_q)
            IDLE: begin
                if (GAME_new_frame_ready) begin
                    act_d   = GAME_next_frame.screen;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = SHIFT_LO;
                end else if (pend_q) begin
                    act_d   = pbuf_q;
                    pend_d  = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_last) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (div_last) begin
                    if (col_q == COL_LAST && row_q == ROW_LAST) begin
                        state_d = LATCH;
                    end else begin
                        state_d = SHIFT_LO;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            LATCH: begin
                if (div_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The active buffer stays frozen; late arrivals overwrite pending.
        if (state_q != IDLE && GAME_new_frame_ready) begin
            pbuf_d = GAME_next_frame.screen;
            pend_d = 1'b1;
        end

        div_d = (state_d != state_q) ? 8'd0 : div_q + 8'd1;

        sclk_d  = (state_d == SHIFT_HI);
        latch_d = (state_d == LATCH);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == LATCH) && (state_d == IDLE);
        sdata_d = 1'b0;
        if (state_d == SHIFT_LO) begin
            sdata_d = act_d[col_d][row_d];
        end else if (state_d == SHIFT_HI) begin
            sdata_d = sdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            div_q   <= '0;
            pend_q  <= 1'b0;
            act_q   <= '0;
            pbuf_q  <= '0;
            sdata_q <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            pbuf_q  <= pbuf_d;
            sdata_q <= sdata_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign DISP_sdata      = sdata_q;
    assign DISP_sclk       = sclk_q;
    assign DISP_latch      = latch_q;
    assign DISP_busy       = busy_q;
    assign DISP_frame_done = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: two instances (CLK_DIV=2 and 1) share stimulus
// and are checked every cycle against a cycle-schedule model.
module tb_frame_serializer;
    import game_state_pkg::*;

    localparam int NB = 200;
    typedef logic [9:0][19:0] screen_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy;
    game_state_t frame;
    logic [1:0]  sd, sc, la, bu, dn;

    always #5 clk = ~clk;

    frame_serializer #(.CLK_DIV(2)) u0 (
        .clk(clk), .reset(reset),
        .GAME_new_frame_ready(rdy), .GAME_next_frame(frame),
        .DISP_sdata(sd[0]), .DISP_sclk(sc[0]), .DISP_latch(la[0]),
        .DISP_busy(bu[0]), .DISP_frame_done(dn[0])
    );

    frame_serializer #(.CLK_DIV(1)) u1 (
        .clk(clk), .reset(reset),
        .GAME_new_frame_ready(rdy), .GAME_next_frame(frame),
        .DISP_sdata(sd[1]), .DISP_sclk(sc[1]), .DISP_latch(la[1]),
        .DISP_busy(bu[1]), .DISP_frame_done(dn[1])
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // model state: a transfer is a schedule indexed by k cycles since start
    int      divs[2] = '{2, 1};
    bit      m_act[2];
    int      m_k[2];
    bit      m_pend[2];
    screen_t m_buf[2];
    screen_t m_pbuf[2];

    // measurements taken from the DUT outputs
    int busy_n[2], rise_n[2], latch_n[2], done_n[2];
    int s_busy[2], s_rise[2], s_latch[2], s_done[2];
    bit prev_sc[2];
    bit samp[2][8192];

    task automatic chk(input string name, input int j, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc=%0d got=%0d expected=%0d", name, j, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int j);
        int tot;
        bit idle;
        tot = (2 * NB + 1) * divs[j];
        if (reset) begin
            m_act[j]  = 1'b0;
            m_pend[j] = 1'b0;
            m_k[j]    = 0;
        end else begin
            idle = !m_act[j] || m_k[j] >= tot;
            if (idle) begin
                if (rdy) begin
                    m_act[j] = 1'b1;
                    m_k[j]   = 0;
                    m_buf[j] = frame.screen;
                end else if (m_pend[j]) begin
                    m_act[j]  = 1'b1;
                    m_k[j]    = 0;
                    m_buf[j]  = m_pbuf[j];
                    m_pend[j] = 1'b0;
                end else begin
                    m_act[j] = 1'b0;
                end
            end else begin
                m_k[j]++;
                if (rdy) begin
                    m_pbuf[j] = frame.screen;
                    m_pend[j] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_out(input int j);
        int d, k, i, tot;
        bit e_sd, e_sc, e_la, e_bu, e_dn;
        d = divs[j];
        tot = (2 * NB + 1) * d;
        k = m_k[j];
        {e_sd, e_sc, e_la, e_bu, e_dn} = 5'b0;
        if (m_act[j]) begin
            if (k < 2 * NB * d) begin
                i    = k / (2 * d);
                e_sc = ((k / d) % 2) == 1;
                e_sd = m_buf[j][i % 10][i / 10];
                e_bu = 1'b1;
            end else if (k < tot) begin
                e_la = 1'b1;
                e_bu = 1'b1;
            end else begin
                e_dn = 1'b1;
            end
        end
        chk("sdata", j, int'(sd[j]), int'(e_sd));
        chk("sclk",  j, int'(sc[j]), int'(e_sc));
        chk("latch", j, int'(la[j]), int'(e_la));
        chk("busy",  j, int'(bu[j]), int'(e_bu));
        chk("done",  j, int'(dn[j]), int'(e_dn));
        if (bu[j]) busy_n[j]++;
        if (la[j]) latch_n[j]++;
        if (dn[j]) done_n[j]++;
        if (sc[j] && !prev_sc[j]) begin
            if (rise_n[j] < 8192) samp[j][rise_n[j]] = sd[j];
            rise_n[j]++;
        end
        prev_sc[j] = sc[j];
    endtask

    task automatic tick();
        @(posedge clk);
        for (int j = 0; j < 2; j++) model_step(j);
        @(negedge clk);
        cyc++;
        for (int j = 0; j < 2; j++) check_out(j);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic snap();
        for (int j = 0; j < 2; j++) begin
            s_busy[j]  = busy_n[j];
            s_rise[j]  = rise_n[j];
            s_latch[j] = latch_n[j];
            s_done[j]  = done_n[j];
        end
    endtask

    task automatic send(input screen_t s);
        frame.screen = s;
        frame.score  = 16'($urandom);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    function automatic int bit_errs(input int j, input int base, input screen_t s);
        int e;
        e = 0;
        for (int i = 0; i < NB; i++)
            if (samp[j][base + i] != s[i % 10][i / 10]) e++;
        return e;
    endfunction

    function automatic screen_t border();
        screen_t s;
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++)
                s[c][r] = (r == 0 || r == 19 || c == 0 || c == 9);
        return s;
    endfunction

    function automatic screen_t pat(input int seed);
        screen_t s;
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++)
                s[c][r] = ((c * 3 + r * 7 + seed) % 5) == 0;
        return s;
    endfunction

    initial begin
        screen_t fa, fb, fc, f1, f2, f3, dig;
        int e, ones;
        reset = 1'b1;
        rdy   = 1'b0;
        frame = '0;
        for (int j = 0; j < 2; j++) begin
            busy_n[j] = 0; rise_n[j] = 0; latch_n[j] = 0; done_n[j] = 0;
            prev_sc[j] = 1'b0; m_act[j] = 1'b0; m_pend[j] = 1'b0; m_k[j] = 0;
        end
        run(3);
        reset = 1'b0;
        tick();
        chk("rst_busy", 0, int'(bu[0]), 0);
        chk("rst_sclk", 1, int'(sc[1]), 0);

        // 1: border frame
        snap();
        send(border());
        run(820);
        chk("t1_busy_len", 0, busy_n[0] - s_busy[0], 802);
        chk("t1_busy_len", 1, busy_n[1] - s_busy[1], 401);
        chk("t1_rises", 0, rise_n[0] - s_rise[0], 200);
        chk("t1_latch_len", 0, latch_n[0] - s_latch[0], 2);
        chk("t1_latch_len", 1, latch_n[1] - s_latch[1], 1);
        chk("t1_done", 0, done_n[0] - s_done[0], 1);
        chk("t1_bits", 0, bit_errs(0, s_rise[0], border()), 0);
        chk("t1_corner_last", 0, int'(samp[0][s_rise[0] + 199]), 1);
        chk("t1_row1_mid", 0, int'(samp[0][s_rise[0] + 15]), 0);

        // 2: digit one at c=5, r=8..12
        dig = '0;
        for (int r = 8; r <= 12; r++) dig[5][r] = 1'b1;
        snap();
        send(dig);
        run(820);
        e = 0;
        ones = 0;
        for (int i = 0; i < NB; i++) begin
            if (samp[1][s_rise[1] + i]) ones++;
            if (samp[1][s_rise[1] + i] !=
                (i == 85 || i == 95 || i == 105 || i == 115 || i == 125)) e++;
        end
        chk("t2_ones", 1, ones, 5);
        chk("t2_positions", 1, e, 0);
        chk("t2_bit85", 1, int'(samp[1][s_rise[1] + 85]), 1);

        // 3: A, then B and C during A; C must replace B
        fa = pat(0);
        fb = pat(1);
        fc = pat(2);
        snap();
        send(fa);
        run(99);
        send(fb);
        run(99);
        send(fc);
        run(1500);
        chk("t3_done", 0, done_n[0] - s_done[0], 2);
        chk("t3_done", 1, done_n[1] - s_done[1], 2);
        chk("t3_busy_len", 0, busy_n[0] - s_busy[0], 1604);
        chk("t3_first_a", 0, bit_errs(0, s_rise[0], fa), 0);
        chk("t3_second_c", 0, bit_errs(0, s_rise[0] + 200, fc), 0);
        chk("t3_second_c", 1, bit_errs(1, s_rise[1] + 200, fc), 0);

        // 4: reset at bit 57 aborts without latching
        snap();
        send(pat(3));
        run(228);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_busy0", 0, int'(bu[0]), 0);
        chk("t4_sclk0", 0, int'(sc[0]), 0);
        chk("t4_sdata0", 0, int'(sd[0]), 0);
        run(20);
        chk("t4_no_latch", 0, latch_n[0] - s_latch[0], 0);
        chk("t4_no_done", 0, done_n[0] - s_done[0], 0);
        chk("t4_partial", 0, rise_n[0] - s_rise[0], 57);
        snap();
        send(pat(4));
        run(820);
        chk("t4_rises", 0, rise_n[0] - s_rise[0], 200);
        chk("t4_bits", 0, bit_errs(0, s_rise[0], pat(4)), 0);

        // 5: ready held three cycles
        f1 = pat(5);
        f2 = ~pat(6);
        f3 = pat(7) ^ border();
        snap();
        rdy = 1'b1;
        frame.screen = f1;
        tick();
        frame.screen = f2;
        tick();
        frame.screen = f3;
        tick();
        rdy = 1'b0;
        run(1700);
        chk("t5_done", 0, done_n[0] - s_done[0], 2);
        chk("t5_first", 0, bit_errs(0, s_rise[0], f1), 0);
        chk("t5_second", 0, bit_errs(0, s_rise[0] + 200, f3), 0);
        chk("t5_rises", 1, rise_n[1] - s_rise[1], 400);

        // 6: all ones
        snap();
        send('1);
        run(420);
        chk("t6_busy_len", 1, busy_n[1] - s_busy[1], 401);
        chk("t6_rises", 1, rise_n[1] - s_rise[1], 200);
        chk("t6_bits", 1, bit_errs(1, s_rise[1], '1), 0);
        run(420);
        chk("t6_rises", 0, rise_n[0] - s_rise[0], 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Sits directly downstream of the game frame encoder.
- Captures a full 10x20 game_state_t frame when GAME_new_frame_ready pulses, then shifts its 200 pixel bits out to a daisy-chained shift-register LED driver (serial data, shift clock, latch).
- Double-buffered: a frame arriving mid-transfer is held as pending (latest wins) and is sent immediately after the current transfer ends.
- The display only updates on the latch pulse, so a partially shifted frame is never shown.

Parameters:
- CLK_DIV, default 4: system clock cycles per shift-clock half-period. Legal range is 1..255.
- N_COLS, default 10: frame columns (index c of screen[c][r]).
- N_ROWS, default 20: frame rows (index r of screen[c][r]).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- GAME_new_frame_ready  input  1  single-cycle pulse: GAME_next_frame is valid this cycle
- GAME_next_frame  input  game_state_pkg::game_state_t  frame to display; only the .screen field is used
- DISP_sdata  output  1  serial pixel data to the driver chain
- DISP_sclk  output  1  shift clock; the driver samples DISP_sdata on the rising edge
- DISP_latch  output  1  latch pulse; transfers the shifted bits to the driver outputs
- DISP_busy  output  1  high while a transfer is in progress
- DISP_frame_done  output  1  one-cycle pulse when a frame has been latched

Behaviour:
- Reset (sampled at the clk edge while reset=1):
  - All outputs go to 0.
  - State goes to IDLE; bit index and divider counter clear to 0.
  - Pending flag clears; both buffers clear to 0.
- Reset mid-transfer aborts the transfer. DISP_latch must not assert for the aborted frame.
- States and transitions:
  - IDLE: sclk=0, latch=0, busy=0.
    - If GAME_new_frame_ready=1: the active buffer takes GAME_next_frame.screen, bit index i=0, next state SHIFT_LO.
    - Otherwise, if pending=1: the active buffer takes the pending buffer, pending clears, next state SHIFT_LO.
  - SHIFT_LO: sclk=0, sdata=bit(i), busy=1. Lasts CLK_DIV cycles, then goes to SHIFT_HI.
  - SHIFT_HI: sclk=1, sdata holds bit(i), busy=1. Lasts CLK_DIV cycles.
    - If i=N_COLS*N_ROWS-1, next state is LATCH.
    - Otherwise i increments and next state is SHIFT_LO.
  - LATCH: latch=1, sclk=0, sdata=0, busy=1. Lasts CLK_DIV cycles, then goes to IDLE.
  - DISP_frame_done=1 for exactly the first cycle after LATCH ends, i.e. the first IDLE cycle.
- Bit order: bit(i) = screen[i mod N_COLS][i div N_COLS].
  - Row 0 is sent first; within a row, column 0 is sent first.
  - First bit out is screen[0][0]; last is screen[N_COLS-1][N_ROWS-1].
- Latency and timing:
  - Capture edge to the first SHIFT_LO cycle: 1 cycle.
  - Busy duration per frame: (2*N_COLS*N_ROWS + 1)*CLK_DIV cycles, which is 1604 for the defaults.
  - Exactly N_COLS*N_ROWS rising edges of DISP_sclk per frame.
  - sdata changes only in the first cycle of SHIFT_LO, never while sclk=1.
- Frame arrival while busy (state is not IDLE):
  - GAME_new_frame_ready copies GAME_next_frame.screen into the pending buffer and sets pending=1.
  - A second arrival overwrites the pending buffer; the latest frame wins.
  - The active buffer is never modified during a transfer.
- Arrival in the done cycle: treated as IDLE. The new frame is captured directly and pending is untouched.
  - If pending is also set, the direct frame takes priority and the pending frame stays pending.
- Divider: an 8-bit counter counts 0..CLK_DIV-1 within each state and resets to 0 on every state change.

Test Plan:
1. Reset, then one frame (border pattern: r=0 or 19, or c=0 or 9; CLK_DIV=2) -> busy for exactly 802 cycles; 200 sclk rising edges; the sampled bitstream equals the border pattern in row-major order; one latch pulse of 2 cycles; one frame_done pulse.
2. Frame showing digit "1" (pixels at c=5, r=8..12), CLK_DIV=1 -> rising-edge samples are 1 exactly at indices 85, 95, 105, 115, 125.
3. Frame A, then frames B and C pulsed at cycles 100 and 200 of A's transfer -> A is latched, then C is sent back-to-back (busy low for one cycle only); B never appears; two frame_done pulses total.
4. Reset asserted at bit 57 of a transfer -> on the next cycle all outputs are 0; no latch pulse; a subsequent frame transfers correctly from bit 0.
5. GAME_new_frame_ready held high for 3 consecutive cycles in IDLE -> first-cycle frame sent; pending holds the third cycle's frame and is sent next.
6. CLK_DIV=1, all-ones frame -> sdata=1 throughout shifting, sclk toggles every cycle, and busy lasts 401 cycles.
